// File: rtl/debug_ocimem_pkg.sv
`default_nettype none
//======================================================================
// debug_ocimem_pkg: shared types and jdo field map for the OCI RAM arbiter
// Rev 1.0
//======================================================================
package debug_ocimem_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 32;
  localparam int JDO_W      = 38;

  // Field positions inside the 38-bit JTAG debug word
  localparam int JDO_ADDR_MSB  = 33;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_RD_FLAG   = 34;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ERR_CLR   = 35;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/debug_ocimem_arbiter.sv
`default_nettype none
//======================================================================
// debug_ocimem_arbiter: shares one OCI RAM port between JTAG and the CPU
// Rev 1.0
//======================================================================
module debug_ocimem_arbiter
  import debug_ocimem_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [JDO_W-1:0] jdo,
  input  logic             take_action_ocimem_a,
  input  logic             take_action_ocimem_b,
  input  logic             take_no_action_ocimem_a,
  input  logic             cpu_req,
  input  logic             cpu_write,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic             cpu_waitrequest,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_rvalid,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_wdata,
  output logic             ram_we,
  input  logic [DW-1:0]    ram_rdata,
  output logic [DW-1:0]    MonDReg,
  output logic             monitor_ready,
  output logic             monitor_error
);

  state_t         state;
  state_t         state_next;

  logic           pend_valid;
  logic           pend_write;
  logic [AW-1:0]  pend_addr;
  logic [DW-1:0]  pend_wdata;
  logic [AW-1:0]  jtag_addr;

  logic           op_jtag;
  logic           op_write;
  logic           last_jtag;

  logic           grant_jtag;
  logic           grant_cpu;
  logic           jtag_done;

  logic [AW-1:0]  jdo_addr;
  logic [DW-1:0]  jdo_wdata;
  logic [AW-1:0]  addr_inc;
  logic [AW-1:0]  cur_addr;
  logic           cmd_any;
  logic           cmd_ok;
  logic           unused_jdo;

  assign jdo_addr   = AW'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
  assign jdo_wdata  = DW'(jdo[JDO_WDATA_MSB:JDO_WDATA_LSB]);
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_ERR_CLR+1], jdo[JDO_WDATA_LSB-1:0]};

  // ram_addr still holds the in-flight JTAG address until the next grant
  assign addr_inc = ram_addr + AW'(1);
  assign cur_addr = jtag_done ? addr_inc : jtag_addr;

  assign monitor_ready   = ~pend_valid & ~((state != ST_IDLE) & op_jtag);
  assign cmd_any         = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cmd_ok          = monitor_ready | jtag_done;
  assign cpu_waitrequest = cpu_req & ~grant_cpu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_jtag = 1'b0;
    grant_cpu  = 1'b0;
    jtag_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!reset) begin
          // On a tie the requester that lost last time wins
          if (pend_valid && (!cpu_req || !last_jtag)) begin
            grant_jtag = 1'b1;
          end else if (cpu_req) begin
            grant_cpu = 1'b1;
          end
          if (grant_jtag || grant_cpu) begin
            state_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (op_write) begin
          state_next = ST_IDLE;
          jtag_done  = op_jtag;
        end else begin
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        state_next = ST_IDLE;
        jtag_done  = op_jtag;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      op_jtag    <= 1'b0;
      op_write   <= 1'b0;
      last_jtag  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      MonDReg    <= '0;
    end else begin
      ram_we     <= 1'b0;
      cpu_rvalid <= 1'b0;
      if (grant_jtag) begin
        ram_addr  <= pend_addr;
        ram_we    <= pend_write;
        op_jtag   <= 1'b1;
        op_write  <= pend_write;
        last_jtag <= 1'b1;
        if (pend_write) begin
          ram_wdata <= pend_wdata;
        end
      end else if (grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_we    <= cpu_write;
        op_jtag   <= 1'b0;
        op_write  <= cpu_write;
        last_jtag <= 1'b0;
        if (cpu_write) begin
          ram_wdata <= cpu_wdata;
        end
      end
      if (state == ST_RD_WAIT) begin
        if (op_jtag) begin
          MonDReg <= ram_rdata;
        end else begin
          cpu_rdata  <= ram_rdata;
          cpu_rvalid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid    <= 1'b0;
      pend_write    <= 1'b0;
      pend_addr     <= '0;
      pend_wdata    <= '0;
      jtag_addr     <= '0;
      monitor_error <= 1'b0;
    end else begin
      if (grant_jtag) begin
        pend_valid <= 1'b0;
      end
      if (jtag_done) begin
        jtag_addr <= addr_inc;
      end
      // A command landing in the completion cycle is accepted; an address
      // load from ocimem_a overrides the auto-increment above
      if (cmd_any) begin
        if (!cmd_ok) begin
          monitor_error <= 1'b1;
        end else if (take_action_ocimem_a) begin
          jtag_addr <= jdo_addr;
          if (jdo[JDO_RD_FLAG]) begin
            pend_valid <= 1'b1;
            pend_write <= 1'b0;
            pend_addr  <= jdo_addr;
          end
          if (jdo[JDO_ERR_CLR]) begin
            monitor_error <= 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          pend_valid <= 1'b1;
          pend_write <= 1'b1;
          pend_addr  <= cur_addr;
          pend_wdata <= jdo_wdata;
        end else begin
          pend_valid <= 1'b1;
          pend_write <= 1'b0;
          pend_addr  <= cur_addr;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/debug_ocimem_arbiter.md
DEBUG_OCIMEM_ARBITER -- requirements
Module: debug_ocimem_arbiter

Interface
REQ-001 Parameter AW, default 8, OCI RAM word-address width.
REQ-002 Parameter DW, default 32, OCI RAM data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 jdo  input  38  JTAG debug data (sysclk domain).
REQ-006 take_action_ocimem_a  input  1  one-cycle pulse: load JTAG address from jdo[33:26]; if jdo[34]=1 also request a JTAG read.
REQ-007 take_action_ocimem_b  input  1  one-cycle pulse: JTAG write of jdo[34:3] at current JTAG address.
REQ-008 take_no_action_ocimem_a  input  1  one-cycle pulse: JTAG read at current JTAG address.
REQ-009 cpu_req / cpu_write  input  1 / 1  CPU access request and direction (1=write).
REQ-010 cpu_addr / cpu_wdata  input  AW / DW  CPU address and write data, held while cpu_waitrequest=1.
REQ-011 cpu_waitrequest  output  1  high while cpu_req is asserted and not accepted.
REQ-012 cpu_rdata / cpu_rvalid  output  DW / 1  CPU read data, qualified by one-cycle cpu_rvalid pulse.
REQ-013 ram_addr / ram_wdata / ram_we  output  AW / DW / 1  OCI RAM port, registered.
REQ-014 ram_rdata  input  DW  OCI RAM read data, valid one cycle after address is presented.
REQ-015 MonDReg  output  DW  last JTAG read data.
REQ-016 monitor_ready  output  1  high when no JTAG operation pending or in flight.
REQ-017 monitor_error  output  1  sticky; set when a JTAG command arrives while monitor_ready=0.

Function
REQ-018 FSM states: IDLE, ACCESS, RD_WAIT.
REQ-019 JTAG commands are latched into a one-deep pending slot (op, addr, data); monitor_ready falls the cycle after acceptance.
REQ-020 A JTAG command arriving while monitor_ready=0 is dropped and sets monitor_error; one arriving in the same cycle the in-flight JTAG op completes is accepted.
REQ-021 IDLE: if only one requester (JTAG pending or cpu_req) is present, grant it; if both, grant the one not granted last; first tie after reset goes to JTAG.
REQ-022 CPU acceptance: cpu_waitrequest=0 in the IDLE cycle the CPU is granted; operands latched that cycle.
REQ-023 Grant cycle N (IDLE) -> ACCESS at N+1: ram_addr/ram_wdata driven, ram_we=1 for writes only.
REQ-024 Write completes in ACCESS; FSM returns to IDLE at N+2; ram_we is high for exactly one cycle.
REQ-025 Read: ACCESS -> RD_WAIT at N+2; ram_rdata captured into MonDReg (JTAG) or cpu_rdata with cpu_rvalid=1 (CPU); IDLE at N+3.
REQ-026 JTAG address auto-increments by 1 after each completed JTAG read or write, modulo 2^AW (wraps 255->0); ocimem_a loads without incrementing.
REQ-027 monitor_ready rises the cycle after the JTAG op completes (ACCESS for write, RD_WAIT for read).
REQ-028 ram_we=0 in IDLE and RD_WAIT; ram_addr holds its last value outside ACCESS.
REQ-029 monitor_error cleared only by reset or a take_action_ocimem_a with jdo[35]=1.

Reset
REQ-030 On reset: state IDLE, pending cleared, JTAG address 0, last-grant = CPU, ram_we 0, ram_addr 0, ram_wdata 0, cpu_rvalid 0, cpu_rdata 0, MonDReg 0, monitor_ready 1, monitor_error 0, cpu_waitrequest follows cpu_req.
REQ-031 Reset mid-operation aborts it: no ram_we, no cpu_rvalid, no MonDReg update in the cycle after reset.

Structure
REQ-032 Package debug_ocimem_pkg holds the state enum, AW/DW defaults and jdo field positions (address 33:26, read flag 34, write data 34:3, error clear 35).
REQ-033 No sub-module; arbitration and FSM inline.

Verification
REQ-034 ocimem_a jdo[33:26]=0x10, jdo[34]=1 with ram[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF, monitor_ready high 4 cycles after pulse, JTAG address 0x11.
REQ-035 JTAG address 0xFF, ocimem_b data 0x12345678 -> ram_we one cycle at addr 0xFF, next address 0x00.
REQ-036 JTAG pending and cpu_req read 0x20 in same IDLE cycle after reset -> JTAG granted first, CPU next; cpu_rvalid 3 cycles after CPU grant.
REQ-037 Second ocimem_b while monitor_ready=0 -> command dropped, monitor_error=1, only one ram_we.
REQ-038 Reset asserted in ACCESS of a CPU read -> no cpu_rvalid, all outputs at REQ-030 values next cycle.
